// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, arbiter FSM states and arbitration mode constants.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RELEASE} arb_state_t;
    typedef logic [2:0] baud_sel_t;
    localparam int ARB_RR      = 0;
    localparam int ARB_RX_PRIO = 1;
endpackage

// File: rtl/baud_arbiter_rr_arb2.sv
// rr_arb2: two-way arbiter, round-robin pointer or fixed priority to req[1], one-hot winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       mode,
    input  logic       adv,
    output logic [1:0] win
);
    logic ptr;
    always_comb win = (req == 2'b11) ? ((mode | ptr) ? 2'b10 : 2'b01) : req;
    // ptr=1 means req[1] is preferred next; it flips away from whoever just won
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr <= 1'b0;
        else if (adv) ptr <= win[0];
endmodule

// File: rtl/baud_arbiter.sv
// baud_arbiter: shares one baud_generator between the UART TX and RX paths,
// launching it for the granted side, routing ticks back and watching for a lost finish.
module baud_arbiter
    import uart_pkg::*;
#(
    parameter int ARB_MODE    = ARB_RR,
    parameter int TIMEOUT_CYC = 1048576,
    parameter int TO_W        = 21
) (
    input  logic      clk,
    input  logic      reset_n,
    input  baud_sel_t cfg_baud_sl,
    input  logic      tx_req,
    input  logic      rx_req,
    output logic      tx_gnt,
    output logic      rx_gnt,
    output logic      tx_tick,
    output logic      rx_tick,
    output logic      tx_done,
    output logic      rx_done,
    output baud_sel_t bg_baud_sl,
    output logic      bg_start,
    output logic      bg_is_tx,
    input  logic      bg_tick,
    input  logic      bg_ready,
    input  logic      bg_finish,
    output logic      busy,
    output logic      timeout_err,
    input  logic      err_clr
);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    arb_state_t      state, state_n;
    logic [TO_W-1:0] cnt;
    logic [1:0]      win;
    logic            go, to_hit, leave;

    assign go      = (state == IDLE) && (tx_req || rx_req) && bg_ready;
    assign to_hit  = (state == BUSY) && !bg_finish && (cnt == TO_LAST);
    assign leave   = (state == BUSY) && (bg_finish || cnt == TO_LAST);
    assign tx_tick = bg_tick & tx_gnt;
    assign rx_tick = bg_tick & rx_gnt;

    rr_arb2 u_arb (
        .clk  (clk),
        .rst_n(reset_n),
        .req  ({rx_req, tx_req}),
        .mode (ARB_MODE == ARB_RX_PRIO),
        .adv  (go),
        .win  (win)
    );

    always_comb begin
        state_n = state;
        state_n = (state == IDLE)   ? (go ? LAUNCH : IDLE) :
                  (state == LAUNCH) ? BUSY :
                  (state == BUSY)   ? (leave ? RELEASE : BUSY) : IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            tx_gnt      <= 1'b0;
            rx_gnt      <= 1'b0;
            tx_done     <= 1'b0;
            rx_done     <= 1'b0;
            bg_baud_sl  <= '0;
            bg_start    <= 1'b0;
            bg_is_tx    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= (state == BUSY) ? cnt + 1'b1 : '0;
            busy     <= (state_n != IDLE);
            bg_start <= go;
            // grant, mode and baud select are frozen from launch until release
            if (go) begin
                tx_gnt     <= win[0];
                rx_gnt     <= win[1];
                bg_is_tx   <= win[0];
                bg_baud_sl <= cfg_baud_sl;
            end else if (state == RELEASE) begin
                tx_gnt <= 1'b0;
                rx_gnt <= 1'b0;
            end
            tx_done     <= leave & tx_gnt;
            rx_done     <= leave & rx_gnt;
            timeout_err <= to_hit | (timeout_err & ~err_clr);
        end
    end
endmodule

// File: tb/tb_baud_arbiter.sv
// tb_baud_arbiter: round-robin and RX-priority arbiters driven side by side by
// randomized frames, compared against a frame-level model of grants, done and errors.
module tb_baud_arbiter;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] cfg_baud_sl = '0;
    logic       tx_req = 1'b0, rx_req = 1'b0;
    logic       bg_tick = 1'b0, bg_ready = 1'b0, bg_finish = 1'b0, err_clr = 1'b0;
    logic [1:0] tx_gnt, rx_gnt, tx_tick, rx_tick, tx_done, rx_done;
    logic [1:0] bg_start, bg_is_tx, busy, timeout_err;
    logic [2:0] bsl [2];

    int n_tests = 0, n_fail = 0;
    bit rr_prev_tx = 1'b0;
    bit exp_err = 1'b0;

    always #5 clk = ~clk;

    baud_arbiter #(.ARB_MODE(0), .TIMEOUT_CYC(TO), .TO_W(7)) u_rr (
        .clk(clk), .reset_n(reset_n), .cfg_baud_sl(cfg_baud_sl),
        .tx_req(tx_req), .rx_req(rx_req), .tx_gnt(tx_gnt[0]), .rx_gnt(rx_gnt[0]),
        .tx_tick(tx_tick[0]), .rx_tick(rx_tick[0]), .tx_done(tx_done[0]), .rx_done(rx_done[0]),
        .bg_baud_sl(bsl[0]), .bg_start(bg_start[0]), .bg_is_tx(bg_is_tx[0]),
        .bg_tick(bg_tick), .bg_ready(bg_ready), .bg_finish(bg_finish),
        .busy(busy[0]), .timeout_err(timeout_err[0]), .err_clr(err_clr)
    );

    baud_arbiter #(.ARB_MODE(1), .TIMEOUT_CYC(TO), .TO_W(7)) u_pr (
        .clk(clk), .reset_n(reset_n), .cfg_baud_sl(cfg_baud_sl),
        .tx_req(tx_req), .rx_req(rx_req), .tx_gnt(tx_gnt[1]), .rx_gnt(rx_gnt[1]),
        .tx_tick(tx_tick[1]), .rx_tick(rx_tick[1]), .tx_done(tx_done[1]), .rx_done(rx_done[1]),
        .bg_baud_sl(bsl[1]), .bg_start(bg_start[1]), .bg_is_tx(bg_is_tx[1]),
        .bg_tick(bg_tick), .bg_ready(bg_ready), .bg_finish(bg_finish),
        .busy(busy[1]), .timeout_err(timeout_err[1]), .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_gnt"}, {tx_gnt[i], rx_gnt[i]}, 0);
            check({tag, "_done"}, {tx_done[i], rx_done[i]}, 0);
            check({tag, "_busy"}, busy[i], 0);
            check({tag, "_start"}, bg_start[i], 0);
        end
    endtask

    // one complete transaction; fin is the BUSY cycle carrying bg_finish, -1 for none
    task automatic frame(input bit t, input bit r, input logic [2:0] cfg, input int fin, input bit clr);
        bit w[2];
        bit to;
        w[0] = (t && r) ? !rr_prev_tx : t;
        w[1] = (t && r) ? 1'b0 : t;
        rr_prev_tx = w[0];
        tx_req = t; rx_req = r; cfg_baud_sl = cfg; bg_ready = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            check("launch_tx_gnt", tx_gnt[i], w[i]);
            check("launch_rx_gnt", rx_gnt[i], !w[i]);
            check("launch_start", bg_start[i], 1);
            check("launch_is_tx", bg_is_tx[i], w[i]);
            check("launch_baud", bsl[i], cfg);
        end
        tx_req = 1'($urandom); rx_req = 1'($urandom); cfg_baud_sl = ~cfg; bg_ready = 1'($urandom);
        for (int k = 0; k < TO; k++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (k == 0) check("busy_start", bg_start[i], 0);
                check("busy_baud", bsl[i], cfg);
                check("busy_gnt", {tx_gnt[i], rx_gnt[i]}, {w[i], !w[i]});
            end
            bg_tick = 1'($urandom);
            #1;
            for (int i = 0; i < 2; i++) begin
                check("tx_tick", tx_tick[i], bg_tick & w[i]);
                check("rx_tick", rx_tick[i], bg_tick & !w[i]);
            end
            bg_finish = (k == fin);
            err_clr = clr && (k == TO - 1);
            if (k == fin) break;
        end
        to = !(fin >= 0 && fin < TO);
        exp_err = to ? 1'b1 : ((clr && fin == TO - 1) ? 1'b0 : exp_err);
        step();
        bg_finish = 1'b0; bg_tick = 1'b0; err_clr = 1'b0;
        tx_req = 1'b0; rx_req = 1'b0; bg_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("rel_tx_done", tx_done[i], w[i]);
            check("rel_rx_done", rx_done[i], !w[i]);
            check("rel_gnt", {tx_gnt[i], rx_gnt[i]}, {w[i], !w[i]});
            check("rel_err", timeout_err[i], exp_err);
        end
        step();
        check_idle("after");
        bg_tick = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) check("idle_tick", {tx_tick[i], rx_tick[i]}, 0);
        bg_tick = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        exp_err = 1'b0;
        for (int i = 0; i < 2; i++) check("err_clr", timeout_err[i], 0);
    endtask

    initial begin
        step();
        check_idle("reset");
        for (int i = 0; i < 2; i++) check("reset_err", timeout_err[i], 0);
        reset_n = 1'b1;
        step();

        frame(1, 0, 3'b110, 5, 0);
        frame(0, 1, 3'b001, 9, 0);
        for (int n = 0; n < 4; n++) frame(1, 1, 3'($urandom), int'($urandom_range(0, 20)), 0);

        frame(1, 0, 3'b011, -1, 0);
        clear_err();
        frame(0, 1, 3'b100, -1, 1);
        clear_err();
        frame(1, 0, 3'b101, TO - 1, 0);

        tx_req = 1'b1; rx_req = 1'b1; bg_ready = 1'b0;
        repeat (3) begin
            step();
            check_idle("not_ready");
        end
        tx_req = 1'b0; rx_req = 1'b0; bg_ready = 1'b1;
        step();

        repeat (30) begin
            logic [1:0] c;
            int fin;
            c = 2'($urandom_range(1, 3));
            fin = int'($urandom_range(0, 79));
            if (fin >= TO) fin = -1;
            frame(c[0], c[1], 3'($urandom), fin, 1'($urandom));
            if ($urandom_range(0, 3) == 0) clear_err();
        end

        frame(0, 1, 3'b010, -1, 0);
        tx_req = 1'b1; cfg_baud_sl = 3'b111;
        step();
        step();
        step();
        #2 reset_n = 1'b0;
        #1;
        check_idle("async_rst");
        for (int i = 0; i < 2; i++) begin
            check("async_rst_err", timeout_err[i], 0);
            check("async_rst_baud", bsl[i], 0);
            check("async_rst_is_tx", bg_is_tx[i], 0);
        end
        bg_finish = 1'b1;
        step();
        reset_n = 1'b1; bg_finish = 1'b0; tx_req = 1'b0;
        rr_prev_tx = 1'b0; exp_err = 1'b0;
        step();
        check_idle("post_rst");
        frame(1, 1, 3'b110, 3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/baud_arbiter.md
Name: baud_arbiter

Overview:
- Shares the single baud_generator between the UART transmitter and receiver paths (half-duplex sharing).
- Grants one requester at a time and launches the generator with the latched baud select and the correct isTx mode.
- Routes tick back to the granted requester only, signals frame completion, and flags a generator that never finishes.
- Sits between the APB config register block, uart_tx/uart_rx and baud_generator.

Parameters:
- ARB_MODE, 0, 0 = round-robin between TX/RX; 1 = fixed RX priority.
- TIMEOUT_CYC, 1048576, max cycles in BUSY before bg_finish is declared lost.
- TO_W, 21, width of timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- cfg_baud_sl  in  3  baud select from config register
- tx_req  in  1  TX path requests generator, level, held until tx_done
- rx_req  in  1  RX path requests generator, level, held until rx_done
- tx_gnt  out  1  TX owns generator
- rx_gnt  out  1  RX owns generator
- tx_tick  out  1  bg_tick gated by tx_gnt
- rx_tick  out  1  bg_tick gated by rx_gnt
- tx_done  out  1  one-cycle pulse, TX frame finished
- rx_done  out  1  one-cycle pulse, RX frame finished
- bg_baud_sl  out  3  baud select to generator
- bg_start  out  1  one-cycle launch pulse to generator
- bg_is_tx  out  1  generator mode (1 = TX, 0 = RX)
- bg_tick  in  1  generator tick
- bg_ready  in  1  generator idle
- bg_finish  in  1  generator frame-end pulse
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky timeout flag
- err_clr  in  1  clears timeout_err

Behaviour:
- Reset: all outputs 0; state IDLE; RR pointer = TX-preferred; timeout counter 0. Reset mid-frame aborts immediately, with no done pulse.
- Registered outputs, except tx_tick/rx_tick, which are combinational ANDs of bg_tick with the registered grant.
- FSM states: IDLE, LAUNCH, BUSY, RELEASE.
- IDLE: if (tx_req|rx_req) & bg_ready, select winner -> LAUNCH. If bg_ready=0, stay in IDLE regardless of requests.
- Winner selection:
  - Only one request: that requester.
  - Both requesting, ARB_MODE=0: the requester not granted last; pointer updates on grant.
  - Both requesting, ARB_MODE=1: RX.
- LAUNCH (1 cycle):
  - gnt of winner = 1; bg_start = 1.
  - bg_is_tx = winner==TX; bg_baud_sl = cfg_baud_sl, captured on the IDLE->LAUNCH edge.
  - -> BUSY.
- BUSY:
  - bg_start = 0; gnt, bg_is_tx and bg_baud_sl held.
  - cfg_baud_sl changes are ignored until the next grant.
  - Timeout counter increments each cycle.
  - bg_finish -> RELEASE.
  - Counter reaching TIMEOUT_CYC-1 without bg_finish -> set timeout_err, go to RELEASE.
- RELEASE (1 cycle): the granted requester's done = 1; gnt still 1; counter cleared -> IDLE, where gnt drops to 0.
- Latency:
  - Request to gnt/bg_start: 1 cycle after req seen with bg_ready=1.
  - bg_finish to done: 1 cycle.
  - Earliest re-grant: 1 cycle after RELEASE.
- Request deassertion in LAUNCH/BUSY is ignored; the frame completes normally.
- bg_finish or bg_tick outside BUSY is ignored; no tick is routed when no grant is held.
- Simultaneous events:
  - bg_finish and timeout in the same cycle: finish wins, no error.
  - err_clr and a timeout set in the same cycle: set wins.
- Grants are one-hot or zero at all times.
- A timed-out generator may still be running; no new grant until bg_ready=1.

Decomposition:
- Package uart_pkg holds:
  - state enum arb_state_t {IDLE, LAUNCH, BUSY, RELEASE};
  - baud_sel_t (3-bit), shared with baud_generator;
  - ARB_RR / ARB_RX_PRIO constants.
- Sub-module rr_arb2: 2-input arbiter with pointer, mode input and one-hot winner output, reusable elsewhere.
- All other logic stays in baud_arbiter.

Test Plan:
- Single TX (the bench uses TIMEOUT_CYC=64 in all scenarios): cfg_baud_sl=3'b110, tx_req=1, bg_ready=1 -> next cycle tx_gnt=1, bg_start=1 for exactly 1 cycle, bg_is_tx=1, bg_baud_sl=110. bg_finish pulse -> tx_done=1 one cycle later, then tx_gnt=0.
- Tick routing: during an RX grant, bg_tick pulses -> rx_tick mirrors them, tx_tick stays 0.
- Contention: tx_req=rx_req=1 held over 4 frames, ARB_MODE=0 -> grants alternate TX,RX,TX,RX. With ARB_MODE=1 -> RX,RX,RX,RX.
- Config stability: cfg_baud_sl changed 3'b110->3'b001 mid-BUSY -> bg_baud_sl stays 110; the next grant carries 001.
- Timeout: no bg_finish -> RELEASE after 64 BUSY cycles, timeout_err=1 and done pulse. err_clr -> 0. err_clr asserted on the timeout cycle -> timeout_err=1. Same-cycle finish and timeout -> no error.
- bg_ready gating and reset: bg_ready=0 with tx_req=1 -> no grant. Assert reset_n=0 mid-BUSY -> all outputs 0 asynchronously, state IDLE, no done pulse.
